rv32i_encoder: RTL



---
 rtl/rv32i_pkg.sv | 56 +++++
 rtl/rv32i_imm_pack.sv | 76 +++++++
 rtl/rv32i_encoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants: opcode classes, major opcodes and funct3 codes.
package rv32i_pkg;

  // Opcode class codes carried on i_class; 11..15 are illegal.
  localparam logic [3:0] CLS_R      = 4'd0;
  localparam logic [3:0] CLS_I      = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_SYSTEM = 4'd9;
  localparam logic [3:0] CLS_FENCE  = 4'd10;

  // 7-bit major opcodes, shared with the decode stage.
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // funct3 codes that change how the word is packed.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // Major opcode for a class; illegal classes map to all-zero.
  function automatic logic [6:0] class_opcode(input logic [3:0] cls);
    logic [6:0] op;
    op = 7'b0;
    case (cls)
      CLS_R:      op = OP_REG;
      CLS_I:      op = OP_IMM;
      CLS_LOAD:   op = OP_LOAD;
      CLS_STORE:  op = OP_STORE;
      CLS_BRANCH: op = OP_BRANCH;
      CLS_JAL:    op = OP_JAL;
      CLS_JALR:   op = OP_JALR;
      CLS_LUI:    op = OP_LUI;
      CLS_AUIPC:  op = OP_AUIPC;
      CLS_SYSTEM: op = OP_SYSTEM;
      CLS_FENCE:  op = OP_FENCE;
      default:    op = 7'b0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational immediate range check and bit placement for each RV32I format.
// imm_field holds the immediate bits (plus the inst[30] selector for R-type and
// shifts) already in their instruction-word positions; all other bits are zero.
module rv32i_imm_pack
  import rv32i_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [31:0] imm,
  output logic        imm_ok,
  output logic [31:0] imm_field
);

  logic is_shift;
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);

  // Per-format range check and immediate scatter.
  always_comb begin
    imm_ok    = 1'b0;
    imm_field = 32'h0;
    case (cls)
      CLS_R: begin
        imm_ok        = 1'b1;
        // Only ADD/SUB and SRL/SRA have an alternate encoding.
        imm_field[30] = alt && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA));
      end
      CLS_I: begin
        if (is_shift) begin
          imm_ok           = (imm[31:5] == 27'h0);
          imm_field[30]    = alt && (funct3 == F3_SRL_SRA);
          imm_field[24:20] = imm[4:0];
        end else begin
          imm_ok           = (&imm[31:11]) || (~|imm[31:11]);
          imm_field[31:20] = imm[11:0];
        end
      end
      CLS_LOAD, CLS_JALR: begin
        imm_ok           = (&imm[31:11]) || (~|imm[31:11]);
        imm_field[31:20] = imm[11:0];
      end
      CLS_STORE: begin
        imm_ok           = (&imm[31:11]) || (~|imm[31:11]);
        imm_field[31:25] = imm[11:5];
        imm_field[11:7]  = imm[4:0];
      end
      CLS_BRANCH: begin
        imm_ok           = ((&imm[31:12]) || (~|imm[31:12])) && !imm[0];
        imm_field[31]    = imm[12];
        imm_field[30:25] = imm[10:5];
        imm_field[11:8]  = imm[4:1];
        imm_field[7]     = imm[11];
      end
      CLS_JAL: begin
        imm_ok           = ((&imm[31:20]) || (~|imm[31:20])) && !imm[0];
        imm_field[31]    = imm[20];
        imm_field[30:21] = imm[10:1];
        imm_field[20]    = imm[11];
        imm_field[19:12] = imm[19:12];
      end
      CLS_LUI, CLS_AUIPC: begin
        imm_ok           = (imm[11:0] == 12'h0);
        imm_field[31:12] = imm[31:12];
      end
      CLS_SYSTEM, CLS_FENCE: begin
        imm_ok           = (imm[31:12] == 20'h0);
        imm_field[31:20] = imm[11:0];
      end
      default: begin
        imm_ok    = 1'b0;
        imm_field = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_encoder.sv
// Two-stage pipelined RV32I instruction encoder with valid/ready on both sides
// and saturating delivered/error counters.
module rv32i_encoder
  import rv32i_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_class,
  input  logic [2:0]       i_funct3,
  input  logic             i_alt,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_inst,
  output logic             o_err,
  output logic [CNT_W-1:0] o_enc_count,
  output logic [CNT_W-1:0] o_err_count
);

  // Whole pipeline advances together; it only freezes when the output is held.
  logic ce;
  assign ce      = !o_valid || i_ready;
  assign o_ready = ce;

  logic        s1_valid;
  logic [6:0]  s1_opcode;
  logic        s1_imm_ok;
  logic [3:0]  s1_class;
  logic [2:0]  s1_funct3;
  logic        s1_alt;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [31:0] s1_imm;

  logic        in_imm_ok;
  logic [31:0] in_imm_field;
  logic        s2_imm_ok;
  logic [31:0] s2_imm_field;

  rv32i_imm_pack u_imm_s1 (
    .cls       (i_class),
    .funct3    (i_funct3),
    .alt       (i_alt),
    .imm       (i_imm),
    .imm_ok    (in_imm_ok),
    .imm_field (in_imm_field)
  );

  rv32i_imm_pack u_imm_s2 (
    .cls       (s1_class),
    .funct3    (s1_funct3),
    .alt       (s1_alt),
    .imm       (s1_imm),
    .imm_ok    (s2_imm_ok),
    .imm_field (s2_imm_field)
  );

  // Stage 1 only needs the range verdict; stage 2 only needs the placement.
  logic unused_pack;
  assign unused_pack = s2_imm_ok ^ (^in_imm_field);

  // Stage 1: register the fields with the selected opcode and range verdict.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid  <= 1'b0;
      s1_opcode <= 7'b0;
      s1_imm_ok <= 1'b0;
      s1_class  <= 4'b0;
      s1_funct3 <= 3'b0;
      s1_alt    <= 1'b0;
      s1_rd     <= 5'b0;
      s1_rs1    <= 5'b0;
      s1_rs2    <= 5'b0;
      s1_imm    <= 32'h0;
    end else if (ce) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_opcode <= class_opcode(i_class);
        s1_imm_ok <= in_imm_ok;
        s1_class  <= i_class;
        s1_funct3 <= i_funct3;
        s1_alt    <= i_alt;
        s1_rd     <= i_rd;
        s1_rs1    <= i_rs1;
        s1_rs2    <= i_rs2;
        s1_imm    <= i_imm;
      end
    end
  end

  // Which register/funct3 fields each class occupies.
  logic use_rd, use_rs1, use_rs2, use_f3;
  logic [31:0] packed_word;

  // Stage 2 packing: OR the register fields into the placed immediate.
  always_comb begin
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    case (s1_class)
      CLS_R:                  begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; end
      CLS_I, CLS_LOAD, CLS_JALR,
      CLS_SYSTEM, CLS_FENCE:  begin use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1; end
      CLS_STORE, CLS_BRANCH:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; end
      CLS_JAL, CLS_LUI,
      CLS_AUIPC:              begin use_rd = 1'b1; end
      default:                begin use_rd = 1'b0; end
    endcase
    packed_word = s2_imm_field | {25'h0, s1_opcode};
    if (use_rd)  packed_word[11:7]  = s1_rd;
    if (use_rs1) packed_word[19:15] = s1_rs1;
    if (use_rs2) packed_word[24:20] = s1_rs2;
    if (use_f3)  packed_word[14:12] = s1_funct3;
  end

  // Stage 2 / output register: unencodable fields emit a zero word with o_err.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_inst  <= 32'h0;
      o_err   <= 1'b0;
    end else if (ce) begin
      o_valid <= s1_valid;
      o_inst  <= (s1_valid && s1_imm_ok) ? packed_word : 32'h0;
      o_err   <= s1_valid && !s1_imm_ok;
    end
  end

  // Saturating counters of delivered words and delivered errors.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_enc_count <= '0;
      o_err_count <= '0;
    end else if (o_valid && i_ready) begin
      if (o_enc_count != '1) o_enc_count <= o_enc_count + CNT_W'(1);
      if (o_err && (o_err_count != '1)) o_err_count <= o_err_count + CNT_W'(1);
    end
  end

endmodule
